// File: rtl/bvh_traversal_stack.sv
// BVH traversal sequencer: picks the nearer hit child, defers the farther one on a LIFO, issues node fetches until empty.
// One node per ISSUE+WAIT pair (>= 2 cycles); either handshake stalls with all outputs held; a push into a full stack is dropped and flagged.
module bvh_traversal_stack #(
    parameter int IDX_W = 32,
    parameter int T_W   = 32,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [IDX_W-1:0]         root_idx,
    output logic                     node_valid,
    input  logic                     node_ready,
    output logic [IDX_W-1:0]         node_idx,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_leaf,
    input  logic [IDX_W-1:0]         left_idx,
    input  logic [IDX_W-1:0]         right_idx,
    input  logic [T_W-1:0]           left_tmin,
    input  logic [T_W-1:0]           left_tmax,
    input  logic [T_W-1:0]           right_tmin,
    input  logic [T_W-1:0]           right_tmax,
    output logic                     busy,
    output logic                     done,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   depth
);

    localparam int AW = $clog2(DEPTH);
    localparam int DW = AW + 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t           state_q;
    logic [IDX_W-1:0] node_idx_q;
    logic             node_valid_q;
    logic             in_ready_q;
    logic             busy_q;
    logic             done_q;
    logic             overflow_q;
    logic [DW-1:0]    depth_q;
    logic [IDX_W-1:0] stack_q [DEPTH];

    logic             accept;
    logic             hit_l;
    logic             hit_r;
    logic             left_near;
    logic             do_pop;
    logic             do_push;
    logic             stack_full;
    logic             stack_empty;
    logic             stack_we;
    logic [AW-1:0]    top_ptr;
    logic [IDX_W-1:0] near_idx;
    logic [IDX_W-1:0] far_idx;
    logic [IDX_W-1:0] next_idx_d;

    assign node_valid = node_valid_q;
    assign node_idx   = node_idx_q;
    assign in_ready   = in_ready_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign overflow   = overflow_q;
    assign depth      = depth_q;

    assign accept      = (state_q == S_WAIT) && in_valid;
    assign stack_full  = (depth_q == DW'(DEPTH));
    assign stack_empty = (depth_q == '0);
    // With depth == DEPTH the low bits wrap to zero, so the subtraction still lands on DEPTH-1.
    assign top_ptr     = depth_q[AW-1:0] - AW'(1);

    always_comb begin
        hit_l      = $signed(left_tmin) <= $signed(left_tmax);
        hit_r      = $signed(right_tmin) <= $signed(right_tmax);
        left_near  = $signed(left_tmin) <= $signed(right_tmin);
        near_idx   = left_near ? left_idx : right_idx;
        far_idx    = left_near ? right_idx : left_idx;
        do_pop     = in_leaf || (!hit_l && !hit_r);
        do_push    = !in_leaf && hit_l && hit_r;
        next_idx_d = stack_q[top_ptr];
        if (!do_pop) begin
            if (do_push) next_idx_d = near_idx;
            else         next_idx_d = hit_l ? left_idx : right_idx;
        end
        stack_we   = accept && do_push && !stack_full;
    end

    always_ff @(posedge clk) begin
        if (stack_we) stack_q[depth_q[AW-1:0]] <= far_idx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            node_idx_q   <= '0;
            node_valid_q <= 1'b0;
            in_ready_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            overflow_q   <= 1'b0;
            depth_q      <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q      <= S_ISSUE;
                        node_idx_q   <= root_idx;
                        depth_q      <= '0;
                        overflow_q   <= 1'b0;
                        node_valid_q <= 1'b1;
                        busy_q       <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (node_ready) begin
                        state_q      <= S_WAIT;
                        node_valid_q <= 1'b0;
                        in_ready_q   <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (in_valid) begin
                        in_ready_q <= 1'b0;
                        if (do_pop && stack_empty) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q      <= S_ISSUE;
                            node_valid_q <= 1'b1;
                            node_idx_q   <= next_idx_d;
                        end
                        if (do_pop && !stack_empty) depth_q <= depth_q - DW'(1);
                        if (do_push) begin
                            if (stack_full) overflow_q <= 1'b1;
                            else            depth_q    <= depth_q + DW'(1);
                        end
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bvh_traversal_stack.sv
// Bench for bvh_traversal_stack (DEPTH=4): directed table, corner sequences, randomized traversals against a queue model.
module tb_bvh_traversal_stack;

    localparam int IW = 32;
    localparam int TW = 32;
    localparam int D  = 4;
    localparam int DW = 3;

    logic          clk;
    logic          rst;
    logic          start;
    logic [IW-1:0] root_idx;
    logic          node_valid;
    logic          node_ready;
    logic [IW-1:0] node_idx;
    logic          in_valid;
    logic          in_ready;
    logic          in_leaf;
    logic [IW-1:0] left_idx;
    logic [IW-1:0] right_idx;
    logic [TW-1:0] left_tmin;
    logic [TW-1:0] left_tmax;
    logic [TW-1:0] right_tmin;
    logic [TW-1:0] right_tmax;
    logic          busy;
    logic          done;
    logic          overflow;
    logic [DW-1:0] depth;

    bvh_traversal_stack #(.IDX_W(IW), .T_W(TW), .DEPTH(D)) dut (
        .clk(clk), .rst(rst), .start(start), .root_idx(root_idx),
        .node_valid(node_valid), .node_ready(node_ready), .node_idx(node_idx),
        .in_valid(in_valid), .in_ready(in_ready), .in_leaf(in_leaf),
        .left_idx(left_idx), .right_idx(right_idx),
        .left_tmin(left_tmin), .left_tmax(left_tmax),
        .right_tmin(right_tmin), .right_tmax(right_tmax),
        .busy(busy), .done(done), .overflow(overflow), .depth(depth)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic              leaf;
        logic [31:0]       li;
        logic [31:0]       ri;
        int                lt0;
        int                lt1;
        int                rt0;
        int                rt1;
        logic              exp_done;
        logic [31:0]       exp_next;
        int                exp_depth;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event did not occur within the cycle bound", name);
    endtask

    task automatic do_start(input logic [31:0] root);
        int n = 0;
        while ((busy || done) && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) timeout_fail("start_wait");
        start = 1'b1;
        root_idx = root;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_issue();
        int n = 0;
        while (!node_valid && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) timeout_fail("node_valid_wait");
    endtask

    task automatic issue_accept(input int delay, output logic [31:0] idx);
        wait_issue();
        repeat (delay) @(negedge clk);
        idx = node_idx;
        node_ready = 1'b1;
        @(negedge clk);
        node_ready = 1'b0;
    endtask

    task automatic send_result(input int delay, input logic leaf, input logic [31:0] li, input logic [31:0] ri,
                               input int lt0, input int lt1, input int rt0, input int rt1);
        int n = 0;
        while (!in_ready && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) timeout_fail("in_ready_wait");
        repeat (delay) @(negedge clk);
        in_leaf    = leaf;
        left_idx   = li;
        right_idx  = ri;
        left_tmin  = lt0;
        left_tmax  = lt1;
        right_tmin = rt0;
        right_tmax = rt1;
        in_valid   = 1'b1;
        @(negedge clk);
        in_valid   = 1'b0;
        in_leaf    = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [31:0] got;
        logic [31:0] exp_idx;
        int          stk [$];
        logic        ovf;
        logic        finished;
        int          steps;

        tbl[0] = '{1'b0, 32'd1,  32'd2,  10, 20,   4, 30, 1'b0, 32'd2,  1};
        tbl[1] = '{1'b1, 32'd0,  32'd0,   0,  0,   0,  0, 1'b0, 32'd1,  0};
        tbl[2] = '{1'b0, 32'd3,  32'd4,   7,  9,   7,  8, 1'b0, 32'd3,  1};
        tbl[3] = '{1'b0, 32'd5,  32'd6,   9,  3,   1,  2, 1'b0, 32'd6,  1};
        tbl[4] = '{1'b0, 32'd7,  32'd8,  -8, -2,  -5, -6, 1'b0, 32'd7,  1};
        tbl[5] = '{1'b0, 32'd11, 32'd12,  5,  1,   3,  2, 1'b0, 32'd4,  0};
        tbl[6] = '{1'b0, 32'd9,  32'd10, -3,  5, -10,  5, 1'b0, 32'd10, 1};
        tbl[7] = '{1'b1, 32'd0,  32'd0,   0,  0,   0,  0, 1'b0, 32'd9,  0};
        tbl[8] = '{1'b1, 32'd0,  32'd0,   0,  0,   0,  0, 1'b1, 32'd0,  0};

        rst = 1'b1; start = 1'b0; root_idx = '0; node_ready = 1'b0; in_valid = 1'b0;
        in_leaf = 1'b0; left_idx = '0; right_idx = '0;
        left_tmin = '0; left_tmax = '0; right_tmin = '0; right_tmax = '0;
        repeat (3) @(negedge clk);
        chk("rst_node_valid", node_valid, 0);
        chk("rst_node_idx", node_idx, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_depth", depth, 0);
        rst = 1'b0;
        @(negedge clk);

        // Root-only leaf
        do_start(32'd5);
        issue_accept(0, got);
        chk("leaf_root_idx", got, 5);
        chk("leaf_busy", busy, 1);
        send_result(0, 1'b1, 0, 0, 0, 0, 0, 0);
        chk("leaf_done", done, 1);
        chk("leaf_depth", depth, 0);
        chk("leaf_overflow", overflow, 0);
        @(negedge clk);
        chk("leaf_done_pulse", done, 0);

        // Directed table
        do_start(32'd0);
        exp_idx = 32'd0;
        for (int i = 0; i < 9; i++) begin
            issue_accept(i % 2, got);
            chk($sformatf("tbl%0d_issue", i), got, exp_idx);
            send_result(i % 3, tbl[i].leaf, tbl[i].li, tbl[i].ri, tbl[i].lt0, tbl[i].lt1, tbl[i].rt0, tbl[i].rt1);
            chk($sformatf("tbl%0d_done", i), done, tbl[i].exp_done);
            chk($sformatf("tbl%0d_depth", i), depth, tbl[i].exp_depth);
            if (!tbl[i].exp_done) exp_idx = tbl[i].exp_next;
        end
        @(negedge clk);
        chk("tbl_done_pulse", done, 0);

        // Overflow: five pushes into a 4-deep stack
        do_start(32'd100);
        exp_idx = 32'd100;
        for (int k = 0; k < 5; k++) begin
            issue_accept(0, got);
            chk($sformatf("ovf_push%0d_issue", k), got, exp_idx);
            send_result(0, 1'b0, 200 + k, 300 + k, 0, 10, 5, 10);
            chk($sformatf("ovf_push%0d_depth", k), depth, (k < 4) ? k + 1 : 4);
            chk($sformatf("ovf_push%0d_flag", k), overflow, k == 4);
            exp_idx = 200 + k;
        end
        for (int j = 0; j < 5; j++) begin
            issue_accept(0, got);
            chk($sformatf("ovf_pop%0d_issue", j), got, exp_idx);
            send_result(0, 1'b1, 0, 0, 0, 0, 0, 0);
            if (j < 4) begin
                chk($sformatf("ovf_pop%0d_depth", j), depth, 3 - j);
                exp_idx = 303 - j;
            end else begin
                chk("ovf_done", done, 1);
            end
        end
        chk("ovf_sticky", overflow, 1);

        // Backpressure, ignored start, reset mid-WAIT
        do_start(32'h77);
        chk("bp_ovf_cleared", overflow, 0);
        wait_issue();
        for (int c = 0; c < 5; c++) begin
            chk("bp_node_valid", node_valid, 1);
            chk("bp_node_idx", node_idx, 32'h77);
            @(negedge clk);
        end
        issue_accept(0, got);
        start = 1'b1; root_idx = 32'h55;
        @(negedge clk);
        start = 1'b0;
        chk("bp_start_ignored_rdy", in_ready, 1);
        chk("bp_start_ignored_vld", node_valid, 0);
        for (int k = 0; k < 3; k++) begin
            send_result(2, 1'b0, 32'h80 + k, 32'h90 + k, 0, 1, 2, 3);
            issue_accept(1, got);
            chk($sformatf("bp_issue%0d", k), got, 32'h80 + k);
        end
        chk("bp_depth3", depth, 3);
        chk("bp_in_wait", in_ready, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_depth", depth, 0);
        chk("mid_rst_node_idx", node_idx, 0);
        chk("mid_rst_node_valid", node_valid, 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("mid_rst_no_done", done, 0);
        end
        rst = 1'b0;
        @(negedge clk);

        // Randomized traversals against a queue model
        for (int t = 0; t < 25; t++) begin
            stk.delete();
            ovf = 1'b0;
            finished = 1'b0;
            steps = 0;
            exp_idx = $urandom;
            do_start(exp_idx);
            while (!finished) begin
                logic        lf;
                logic [31:0] li;
                logic [31:0] ri;
                int          a0, a1, b0, b1;
                logic        hl, hr;
                issue_accept($urandom_range(0, 2), got);
                chk("rnd_issue", got, exp_idx);
                lf = (steps >= 30) || ($urandom_range(0, 5) == 0);
                li = $urandom;
                ri = $urandom;
                a0 = int'($urandom_range(0, 40)) - 20;
                a1 = int'($urandom_range(0, 40)) - 20;
                b0 = int'($urandom_range(0, 40)) - 20;
                b1 = int'($urandom_range(0, 40)) - 20;
                send_result($urandom_range(0, 2), lf, li, ri, a0, a1, b0, b1);
                hl = a0 <= a1;
                hr = b0 <= b1;
                if (lf || (!hl && !hr)) begin
                    if (stk.size() == 0) finished = 1'b1;
                    else exp_idx = stk.pop_back();
                end else if (hl && hr) begin
                    if (stk.size() == D) ovf = 1'b1;
                    else stk.push_back(a0 <= b0 ? ri : li);
                    exp_idx = (a0 <= b0) ? li : ri;
                end else begin
                    exp_idx = hl ? li : ri;
                end
                chk("rnd_depth", depth, stk.size());
                chk("rnd_overflow", overflow, ovf);
                chk("rnd_done", done, finished);
                steps++;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
